// File: rtl/matrix_op_dispatcher.sv
// matrix_op_dispatcher
// Accepts one validated matrix operation request, fetches the operand
// dimensions from matrix-storage metadata, re-checks shape compatibility,
// starts the matching compute unit and returns a status/result-dimension
// response to the operation selector.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_*                      request handshake from the selector
//   meta_rd_*, meta_rows/cols  metadata read strobe and returned dimensions
//   unit_*                     one-hot unit start, latched operands, done/error
//   rsp_*                      response handshake back to the selector
module matrix_op_dispatcher #(
  parameter int ID_WIDTH       = 3,
  parameter int DIM_WIDTH      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_calc_type,
  input  logic [ID_WIDTH-1:0]   req_id_a,
  input  logic [ID_WIDTH-1:0]   req_id_b,
  input  logic [DATA_WIDTH-1:0] req_scalar,
  output logic                  meta_rd_en,
  output logic [ID_WIDTH-1:0]   meta_rd_id,
  input  logic                  meta_rd_valid,
  input  logic [DIM_WIDTH-1:0]  meta_rows,
  input  logic [DIM_WIDTH-1:0]  meta_cols,
  output logic [4:0]            unit_start,
  output logic [ID_WIDTH-1:0]   unit_id_a,
  output logic [ID_WIDTH-1:0]   unit_id_b,
  output logic [DATA_WIDTH-1:0] unit_scalar,
  input  logic [4:0]            unit_done,
  input  logic                  unit_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [DIM_WIDTH-1:0]  rsp_rows,
  output logic [DIM_WIDTH-1:0]  rsp_cols
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CT_TRANSPOSE = 3'd0;
  localparam logic [2:0] CT_ADD       = 3'd1;
  localparam logic [2:0] CT_MUL       = 3'd2;
  localparam logic [2:0] CT_SCALAR    = 3'd3;
  localparam logic [2:0] CT_CONV      = 3'd4;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_DIM_ERR  = 2'd1;
  localparam logic [1:0] ST_UNIT_ERR = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH_A = 4'd1,
    S_WAIT_A  = 4'd2,
    S_FETCH_B = 4'd3,
    S_WAIT_B  = 4'd4,
    S_CHECK   = 4'd5,
    S_START   = 4'd6,
    S_RUN     = 4'd7,
    S_RESPOND = 4'd8
  } state_t;

  state_t                state_r, state_s;
  logic [2:0]            calc_type_r;
  logic [ID_WIDTH-1:0]   id_a_r, id_b_r;
  logic [DATA_WIDTH-1:0] scalar_r;
  logic [DIM_WIDTH-1:0]  rows_a_r, cols_a_r, rows_b_r, cols_b_r;
  logic [DIM_WIDTH-1:0]  res_rows_r, res_cols_r;
  logic [1:0]            rsp_status_r;
  logic [DIM_WIDTH-1:0]  rsp_rows_r, rsp_cols_r;
  logic [CNT_W-1:0]      cnt_r;

  logic                  two_op_s, zero_dim_s, rule_ok_s, chk_pass_s, done_s, cnt_last_s;
  logic [DIM_WIDTH-1:0]  chk_rows_s, chk_cols_s;
  logic [4:0]            start_vec_s;

  assign unit_id_a   = id_a_r;
  assign unit_id_b   = id_b_r;
  assign unit_scalar = scalar_r;
  assign rsp_status  = rsp_status_r;
  assign rsp_rows    = rsp_rows_r;
  assign rsp_cols    = rsp_cols_r;
  assign cnt_last_s  = (cnt_r == CNT_LAST);
  assign chk_pass_s  = rule_ok_s & ~zero_dim_s;

  // Shape rules, result dimensions, unit selection and done selection per calc type
  always_comb begin
    two_op_s    = 1'b0;
    rule_ok_s   = 1'b0;
    chk_rows_s  = '0;
    chk_cols_s  = '0;
    start_vec_s = 5'b00000;
    done_s      = 1'b0;
    case (calc_type_r)
      CT_TRANSPOSE: begin
        rule_ok_s   = 1'b1;
        chk_rows_s  = cols_a_r;
        chk_cols_s  = rows_a_r;
        start_vec_s = 5'b00001;
        done_s      = unit_done[0];
      end
      CT_ADD: begin
        two_op_s    = 1'b1;
        rule_ok_s   = (rows_a_r == rows_b_r) && (cols_a_r == cols_b_r);
        chk_rows_s  = rows_a_r;
        chk_cols_s  = cols_a_r;
        start_vec_s = 5'b00010;
        done_s      = unit_done[1];
      end
      CT_MUL: begin
        two_op_s    = 1'b1;
        rule_ok_s   = (cols_a_r == rows_b_r);
        chk_rows_s  = rows_a_r;
        chk_cols_s  = cols_b_r;
        start_vec_s = 5'b00100;
        done_s      = unit_done[2];
      end
      CT_SCALAR: begin
        rule_ok_s   = 1'b1;
        chk_rows_s  = rows_a_r;
        chk_cols_s  = cols_a_r;
        start_vec_s = 5'b01000;
        done_s      = unit_done[3];
      end
      CT_CONV: begin
        two_op_s    = 1'b1;
        rule_ok_s   = (rows_b_r <= rows_a_r) && (cols_b_r <= cols_a_r);
        // B is the kernel; only valid (non-padded) output positions are produced
        chk_rows_s  = rows_a_r - rows_b_r + DIM_WIDTH'(1);
        chk_cols_s  = cols_a_r - cols_b_r + DIM_WIDTH'(1);
        start_vec_s = 5'b10000;
        done_s      = unit_done[4];
      end
      default: begin
        rule_ok_s = 1'b0;
      end
    endcase
    zero_dim_s = (rows_a_r == '0) || (cols_a_r == '0) ||
                 (two_op_s && ((rows_b_r == '0) || (cols_b_r == '0)));
  end

  // Next-state decode and state-derived handshake/strobe outputs
  always_comb begin
    state_s    = state_r;
    req_ready  = 1'b0;
    meta_rd_en = 1'b0;
    meta_rd_id = '0;
    unit_start = 5'b00000;
    rsp_valid  = 1'b0;
    case (state_r)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_s = (req_calc_type > CT_CONV) ? S_RESPOND : S_FETCH_A;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH_A: begin
        meta_rd_en = 1'b1;
        meta_rd_id = id_a_r;
        state_s    = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (meta_rd_valid) begin
          state_s = two_op_s ? S_FETCH_B : S_CHECK;
        end else begin
          state_s = S_WAIT_A;
        end
      end
      S_FETCH_B: begin
        meta_rd_en = 1'b1;
        meta_rd_id = id_b_r;
        state_s    = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (meta_rd_valid) begin
          state_s = S_CHECK;
        end else begin
          state_s = S_WAIT_B;
        end
      end
      S_CHECK: begin
        state_s = chk_pass_s ? S_START : S_RESPOND;
      end
      S_START: begin
        unit_start = start_vec_s;
        state_s    = S_RUN;
      end
      S_RUN: begin
        if (unit_error || done_s || cnt_last_s) begin
          state_s = S_RESPOND;
        end else begin
          state_s = S_RUN;
        end
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESPOND;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Request latch, metadata capture, run counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_type_r  <= 3'd0;
      id_a_r       <= '0;
      id_b_r       <= '0;
      scalar_r     <= '0;
      rows_a_r     <= '0;
      cols_a_r     <= '0;
      rows_b_r     <= '0;
      cols_b_r     <= '0;
      res_rows_r   <= '0;
      res_cols_r   <= '0;
      rsp_status_r <= ST_OK;
      rsp_rows_r   <= '0;
      rsp_cols_r   <= '0;
      cnt_r        <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            calc_type_r <= req_calc_type;
            id_a_r      <= req_id_a;
            id_b_r      <= req_id_b;
            scalar_r    <= req_scalar;
            rows_a_r    <= '0;
            cols_a_r    <= '0;
            rows_b_r    <= '0;
            cols_b_r    <= '0;
            if (req_calc_type > CT_CONV) begin
              rsp_status_r <= ST_DIM_ERR;
              rsp_rows_r   <= '0;
              rsp_cols_r   <= '0;
            end
          end
        end
        S_WAIT_A: begin
          if (meta_rd_valid) begin
            rows_a_r <= meta_rows;
            cols_a_r <= meta_cols;
          end
        end
        S_WAIT_B: begin
          if (meta_rd_valid) begin
            rows_b_r <= meta_rows;
            cols_b_r <= meta_cols;
          end
        end
        S_CHECK: begin
          if (chk_pass_s) begin
            res_rows_r <= chk_rows_s;
            res_cols_r <= chk_cols_s;
          end else begin
            rsp_status_r <= ST_DIM_ERR;
            rsp_rows_r   <= '0;
            rsp_cols_r   <= '0;
          end
        end
        S_START: begin
          cnt_r <= '0;
        end
        S_RUN: begin
          // error outranks done, and done outranks the timeout on the final cycle
          if (unit_error) begin
            rsp_status_r <= ST_UNIT_ERR;
            rsp_rows_r   <= '0;
            rsp_cols_r   <= '0;
          end else if (done_s) begin
            rsp_status_r <= ST_OK;
            rsp_rows_r   <= res_rows_r;
            rsp_cols_r   <= res_cols_r;
          end else if (cnt_last_s) begin
            rsp_status_r <= ST_TIMEOUT;
            rsp_rows_r   <= '0;
            rsp_cols_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            rsp_status_r <= ST_OK;
            rsp_rows_r   <= '0;
            rsp_cols_r   <= '0;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Directed testbench for matrix_op_dispatcher: a metadata responder returns
// slot dimensions one cycle after each read strobe, and a compute-unit model
// pulses done/error a programmed number of RUN cycles after unit_start.
module tb_matrix_op_dispatcher;

  localparam int IW = 3;
  localparam int DW = 3;
  localparam int XW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [2:0]    req_calc_type;
  logic [IW-1:0] req_id_a, req_id_b;
  logic [XW-1:0] req_scalar;
  logic          meta_rd_en;
  logic [IW-1:0] meta_rd_id;
  logic          meta_rd_valid = 1'b0;
  logic [DW-1:0] meta_rows = 3'd0, meta_cols = 3'd0;
  logic [4:0]    unit_start;
  logic [IW-1:0] unit_id_a, unit_id_b;
  logic [XW-1:0] unit_scalar;
  logic [4:0]    unit_done = 5'd0;
  logic          unit_error = 1'b0;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_rows, rsp_cols;

  int checks = 0;
  int errors = 0;

  // slot dimension table
  logic [DW-1:0] m_rows [8];
  logic [DW-1:0] m_cols [8];

  // metadata responder state
  logic          meta_pend = 1'b0;
  logic [IW-1:0] meta_pend_id = 3'd0;
  int            meta_log [$];

  // compute-unit model controls (main thread) and state (model)
  logic [2:0] u_type = 3'd0;
  int         u_delay = 0;
  int         u_err = 0;
  logic [4:0] u_noise = 5'd0;
  logic       u_armed = 1'b0;
  int         u_k = 0;
  int         start_cnt = 0;
  logic [4:0] last_start = 5'd0;
  logic [IW-1:0] st_ida = 3'd0, st_idb = 3'd0;
  logic [XW-1:0] st_scalar = 32'd0;

  matrix_op_dispatcher #(
    .ID_WIDTH(IW), .DIM_WIDTH(DW), .DATA_WIDTH(XW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_calc_type(req_calc_type),
    .req_id_a(req_id_a), .req_id_b(req_id_b), .req_scalar(req_scalar),
    .meta_rd_en(meta_rd_en), .meta_rd_id(meta_rd_id), .meta_rd_valid(meta_rd_valid),
    .meta_rows(meta_rows), .meta_cols(meta_cols),
    .unit_start(unit_start), .unit_id_a(unit_id_a), .unit_id_b(unit_id_b),
    .unit_scalar(unit_scalar), .unit_done(unit_done), .unit_error(unit_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_rows(rsp_rows), .rsp_cols(rsp_cols)
  );

  always #5 clk = ~clk;

  // metadata returns one cycle after the strobe
  always @(negedge clk) begin
    meta_rd_valid <= meta_pend;
    meta_rows     <= meta_pend ? m_rows[meta_pend_id] : 3'd0;
    meta_cols     <= meta_pend ? m_cols[meta_pend_id] : 3'd0;
    meta_pend     <= meta_rd_en;
    meta_pend_id  <= meta_rd_id;
    if (meta_rd_en) meta_log.push_back(int'(meta_rd_id));
  end

  // compute unit: done/error on programmed RUN cycle index (1 = first RUN cycle)
  always @(negedge clk) begin
    if (unit_start != 5'd0) begin
      u_armed    <= 1'b1;
      u_k        <= 0;
      unit_done  <= 5'd0;
      unit_error <= 1'b0;
      start_cnt  <= start_cnt + 1;
      last_start <= unit_start;
      st_ida     <= unit_id_a;
      st_idb     <= unit_id_b;
      st_scalar  <= unit_scalar;
    end else if (u_armed) begin
      u_k        <= u_k + 1;
      unit_done  <= (((u_k + 1) == u_delay) ? (5'd1 << u_type) : 5'd0) | u_noise;
      unit_error <= ((u_k + 1) == u_err);
      if (u_k > 40) u_armed <= 1'b0;
    end else begin
      unit_done  <= 5'd0;
      unit_error <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] ct, input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                        input logic [XW-1:0] sc);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_calc_type = ct;
    req_id_a      = ia;
    req_id_b      = ib;
    req_scalar    = sc;
    u_type        = ct;
    @(posedge clk);
    @(negedge clk);
    req_valid     = 1'b0;
  endtask

  // waits for rsp_valid, checks latency/status/dims, then completes the handshake
  task automatic expect_rsp(input string tag, input int exp_lat, input logic [1:0] st,
                            input logic [DW-1:0] r, input logic [DW-1:0] c);
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_status"}, 32'(rsp_status), 32'(st));
    check_eq({tag, "_rows"}, 32'(rsp_rows), 32'(r));
    check_eq({tag, "_cols"}, 32'(rsp_cols), 32'(c));
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, m0, bad;
    m_rows[0] = 3'd0; m_cols[0] = 3'd0;
    m_rows[1] = 3'd2; m_cols[1] = 3'd3;
    m_rows[2] = 3'd3; m_cols[2] = 3'd4;
    m_rows[3] = 3'd3; m_cols[3] = 3'd2;
    m_rows[4] = 3'd3; m_cols[4] = 3'd5;
    m_rows[5] = 3'd5; m_cols[5] = 3'd5;
    m_rows[6] = 3'd3; m_cols[6] = 3'd3;
    m_rows[7] = 3'd1; m_cols[7] = 3'd1;
    rst_n = 1'b0; req_valid = 1'b0; req_calc_type = 3'd0; req_id_a = 3'd0;
    req_id_b = 3'd0; req_scalar = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_meta_en", 32'(meta_rd_en), 32'd0);
    check_eq("rst_unit_start", 32'(unit_start), 32'd0);
    check_eq("rst_rsp_status", 32'(rsp_status), 32'd0);

    // MUL 2x3 * 3x4, done on 10th RUN cycle
    s0 = start_cnt; m0 = meta_log.size(); u_delay = 10;
    do_req(3'd2, 3'd1, 3'd2, 32'h0000_0011);
    expect_rsp("mul", 16, 2'd0, 3'd2, 3'd4);
    check_eq("mul_nreads", 32'(meta_log.size() - m0), 32'd2);
    check_eq("mul_read_a", 32'(meta_log[m0]), 32'd1);
    check_eq("mul_read_b", 32'(meta_log[m0 + 1]), 32'd2);
    check_eq("mul_nstart", 32'(start_cnt - s0), 32'd1);
    check_eq("mul_start_vec", 32'(last_start), 32'b00100);
    check_eq("mul_id_a", 32'(st_ida), 32'd1);
    check_eq("mul_id_b", 32'(st_idb), 32'd2);
    check_eq("mul_scalar", st_scalar, 32'h0000_0011);
    ack_rsp("mul");

    // MUL minimum latency, done on first RUN cycle
    u_delay = 1;
    do_req(3'd2, 3'd1, 3'd2, 32'd0);
    expect_rsp("mul_fast", 7, 2'd0, 3'd2, 3'd4);
    ack_rsp("mul_fast");

    // ADD 2x3 + 3x2 -> shape error, no start
    s0 = start_cnt;
    do_req(3'd1, 3'd1, 3'd3, 32'd0);
    expect_rsp("add_bad", 5, 2'd1, 3'd0, 3'd0);
    check_eq("add_bad_nstart", 32'(start_cnt - s0), 32'd0);
    ack_rsp("add_bad");

    // TRANSPOSE 3x5 -> 5x3, single read
    m0 = meta_log.size(); u_delay = 1;
    do_req(3'd0, 3'd4, 3'd7, 32'd0);
    expect_rsp("tr", 5, 2'd0, 3'd5, 3'd3);
    check_eq("tr_nreads", 32'(meta_log.size() - m0), 32'd1);
    check_eq("tr_read_a", 32'(meta_log[m0]), 32'd4);
    check_eq("tr_start_vec", 32'(last_start), 32'b00001);
    ack_rsp("tr");

    // CONV 5x5 with 3x3 kernel -> 3x3
    do_req(3'd4, 3'd5, 3'd6, 32'd0);
    expect_rsp("conv", 7, 2'd0, 3'd3, 3'd3);
    check_eq("conv_start_vec", 32'(last_start), 32'b10000);
    ack_rsp("conv");

    // SCALAR_MUL with no done, stray unit_done[0] -> TIMEOUT after 16 RUN cycles
    u_delay = 0; u_noise = 5'b00001;
    do_req(3'd3, 3'd1, 3'd0, 32'hDEAD_BEEF);
    expect_rsp("tmo", 20, 2'd3, 3'd0, 3'd0);
    check_eq("tmo_start_vec", 32'(last_start), 32'b01000);
    check_eq("tmo_scalar", st_scalar, 32'hDEAD_BEEF);
    ack_rsp("tmo");
    u_noise = 5'd0;

    // done and error on the same cycle -> UNIT_ERR
    u_delay = 3; u_err = 3;
    do_req(3'd2, 3'd1, 3'd2, 32'd0);
    expect_rsp("uerr", 9, 2'd2, 3'd0, 3'd0);
    ack_rsp("uerr");
    u_err = 0;

    // response back-pressure: fields stable, no new request accepted
    u_delay = 1;
    do_req(3'd1, 3'd1, 3'd1, 32'd0);
    expect_rsp("stall", 7, 2'd0, 3'd2, 3'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_rows !== 3'd2 ||
          rsp_cols !== 3'd3 || req_ready !== 1'b0) bad++;
    end
    check_eq("stall_hold", 32'(bad), 32'd0);
    ack_rsp("stall");

    // illegal calc type -> DIM_ERR straight away, no reads
    m0 = meta_log.size();
    do_req(3'd6, 3'd1, 3'd2, 32'd0);
    expect_rsp("ct6", 0, 2'd1, 3'd0, 3'd0);
    repeat (2) @(negedge clk);
    check_eq("ct6_nreads", 32'(meta_log.size() - m0), 32'd0);
    ack_rsp("ct6");

    // empty slot -> DIM_ERR
    s0 = start_cnt;
    do_req(3'd0, 3'd0, 3'd0, 32'd0);
    expect_rsp("empty", 3, 2'd1, 3'd0, 3'd0);
    check_eq("empty_nstart", 32'(start_cnt - s0), 32'd0);
    ack_rsp("empty");

    // reset while RUN; late done from the unit must be ignored
    u_delay = 10;
    do_req(3'd2, 3'd1, 3'd2, 32'h0000_00A5);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_outs", 32'({unit_start, meta_rd_en, rsp_valid, rsp_status}), 32'd0);
    check_eq("mid_rst_ids", 32'({unit_id_a, unit_id_b}), 32'd0);
    check_eq("mid_rst_scalar", unit_scalar, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || meta_rd_en !== 1'b0) bad++;
    end
    check_eq("post_rst_idle", 32'(bad), 32'd0);
    u_delay = 1;
    do_req(3'd4, 3'd5, 3'd6, 32'd0);
    expect_rsp("post_rst_conv", 7, 2'd0, 3'd3, 3'd3);
    ack_rsp("post_rst_conv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_op_dispatcher.md
Name: matrix_op_dispatcher

Overview:
- Responder on the far end of the matrix operation selector's hand-off: accepts one validated operation request (calc type, operand IDs, scalar).
- Fetches operand dimensions from matrix-storage metadata, re-checks shape compatibility and computes result dimensions.
- Pulses the start line of the matching compute unit, waits for its completion, and returns a status/result-dimension response to the selector.

Parameters:
ID_WIDTH, 3, width of matrix slot IDs
DIM_WIDTH, 3, width of row/column counts (0 = empty slot)
DATA_WIDTH, 32, scalar operand width
TIMEOUT_CYCLES, 1048576, max RUN cycles before abort (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req_valid  in  1  request present
req_ready  out  1  dispatcher can accept
req_calc_type  in  3  0 TRANSPOSE, 1 ADD, 2 MUL, 3 SCALAR_MUL, 4 CONV
req_id_a  in  ID_WIDTH  operand A slot
req_id_b  in  ID_WIDTH  operand B slot
req_scalar  in  DATA_WIDTH  scalar for SCALAR_MUL
meta_rd_en  out  1  metadata read strobe (1-cycle pulse)
meta_rd_id  out  ID_WIDTH  slot being read
meta_rd_valid  in  1  metadata return valid
meta_rows  in  DIM_WIDTH  returned rows
meta_cols  in  DIM_WIDTH  returned cols
unit_start  out  5  one-hot start, bit index = calc type
unit_id_a  out  ID_WIDTH  latched A
unit_id_b  out  ID_WIDTH  latched B
unit_scalar  out  DATA_WIDTH  latched scalar
unit_done  in  5  per-unit done pulses
unit_error  in  1  active unit error
rsp_valid  out  1  response present
rsp_ready  in  1  selector accepts response
rsp_status  out  2  0 OK, 1 DIM_ERR, 2 UNIT_ERR, 3 TIMEOUT
rsp_rows  out  DIM_WIDTH  result rows (0 unless OK)
rsp_cols  out  DIM_WIDTH  result cols (0 unless OK)

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. Reset (including mid-operation) forces IDLE, clears timeout counter and all latched fields; all outputs 0 except req_ready=1 once in IDLE. A unit already started is not aborted; its later done is ignored.
- States: IDLE, FETCH_A, WAIT_A, FETCH_B, WAIT_B, CHECK, START, RUN, RESPOND.
- IDLE: req_ready=1 only here. On req_valid&req_ready, latch type/IDs/scalar → FETCH_A. calc_type 5..7 → RESPOND with DIM_ERR, no metadata reads.
- FETCH_A: meta_rd_en=1, meta_rd_id=id_a for one cycle → WAIT_A. WAIT_A: on meta_rd_valid latch rows_a/cols_a; TRANSPOSE/SCALAR_MUL → CHECK, others → FETCH_B. FETCH_B/WAIT_B identical for id_b. Wait unbounded for meta_rd_valid; meta_rd_valid outside WAIT_x ignored.
- CHECK (1 cycle): any fetched dim 0 → DIM_ERR. Rules / result:
  TRANSPOSE: cols_a x rows_a.
  ADD: rows_a==rows_b and cols_a==cols_b; result rows_a x cols_a.
  MUL: cols_a==rows_b; result rows_a x cols_b.
  SCALAR_MUL: rows_a x cols_a.
  CONV (B = kernel): rows_b<=rows_a and cols_b<=cols_a; result (rows_a-rows_b+1) x (cols_a-cols_b+1), computed in DIM_WIDTH unsigned, no overflow possible.
  Fail → RESPOND with DIM_ERR, no unit_start. Pass → START.
- START: unit_start[calc_type]=1 for exactly one cycle; unit_id_a/b/scalar held stable from START until leaving RUN → RUN; counter cleared.
- RUN: sample only unit_done[calc_type]; other bits ignored. unit_error=1 → UNIT_ERR (wins over simultaneous done). Done → OK with computed dims. Counter increments each RUN cycle; reaching TIMEOUT_CYCLES without done/error → TIMEOUT. Done on the cycle the count reaches the limit wins.
- RESPOND: rsp_valid=1, status/dims stable until rsp_valid&rsp_ready → IDLE next cycle. rsp_rows/cols = 0 for non-OK.
- Latency, OK path, meta returns 1 cycle after strobe, unit done on first RUN cycle: 2-operand request accepted cycle 0 → rsp_valid cycle 7; 1-operand cycle 5.

Test Plan:
- MUL, A=2x3, B=3x4, done after 10 RUN cycles → reads ids A then B, unit_start=5'b00100 once, rsp OK rows=2 cols=4.
- ADD, A=2x3, B=3x2 → DIM_ERR, rows=cols=0, unit_start never asserted.
- TRANSPOSE, A=3x5 → single meta read, unit_start=5'b00001, rsp OK rows=5 cols=3; CONV A=5x5 B=3x3 → OK 3x3.
- TIMEOUT_CYCLES=16, SCALAR_MUL, no done → TIMEOUT after 16 RUN cycles; unit_done[0] during RUN ignored; done+error same cycle → UNIT_ERR.
- rsp_ready low 5 cycles → rsp fields stable, req_ready low; calc_type=6 → DIM_ERR without meta reads; slot returning 0x0 → DIM_ERR.
- rst_n low during RUN → outputs 0 immediately, IDLE, req_ready=1 after release; subsequent request completes normally.
